// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Packs decoded instruction fields into 16-bit words and writes them to
// consecutive instruction-memory addresses during a load session.
// Optional readback-and-compare of every written word is enabled by
// defining INSTR_ENC_READBACK_EN.

module instr_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [4:0]        opcode,
  input  logic [2:0]        rd,
  input  logic [2:0]        rm,
  input  logic [2:0]        rn,
  input  logic [1:0]        alu_op,
  input  logic [10:0]       imm,
  input  logic [3:0]        cond,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
`ifdef INSTR_ENC_READBACK_EN
  ,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata,
  output logic              mismatch
`endif
);

`ifdef INSTR_ENC_READBACK_EN
  typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, DONE, READ, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;
`endif

  localparam logic [ADDR_W:0] ONE_WORD = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W:0]   remaining;
  logic [15:0]       enc_word;
  logic              fmt_legal;

  // Combinational field packer; formats 5-7 are flagged illegal
  always_comb begin
    enc_word  = 16'h0000;
    fmt_legal = 1'b1;
    case (fmt)
      3'd0:    enc_word = {opcode, rd, rm, rn, alu_op};
      3'd1:    enc_word = {opcode, rd, imm[7:0]};
      3'd2:    enc_word = {opcode, rd, rm, imm[4:0]};
      3'd3:    enc_word = {opcode, imm[10:0]};
      3'd4:    enc_word = {opcode[4:1], cond, imm[7:0]};
      default: fmt_legal = 1'b0;
    endcase
  end

  // Session FSM with all outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      remaining     <= '0;
      in_ready      <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_data      <= 16'h0000;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      words_written <= '0;
`ifdef INSTR_ENC_READBACK_EN
      mem_re        <= 1'b0;
      mismatch      <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
`ifdef INSTR_ENC_READBACK_EN
      mem_re <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            mem_addr      <= base_addr;
            remaining     <= count;
            err           <= 1'b0;
            words_written <= '0;
            busy          <= 1'b1;
`ifdef INSTR_ENC_READBACK_EN
            mismatch      <= 1'b0;
`endif
            if (count == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= ACCEPT;
              in_ready <= 1'b1;
            end
          end
        end

        ACCEPT: begin
          if (in_valid) begin
            if (fmt_legal) begin
              mem_data <= enc_word;
              mem_we   <= 1'b1;
              in_ready <= 1'b0;
              state    <= WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end

        WRITE: begin
`ifdef INSTR_ENC_READBACK_EN
          mem_re <= 1'b1;
          state  <= READ;
`else
          mem_addr      <= mem_addr + 1'b1;
          remaining     <= remaining - 1'b1;
          words_written <= words_written + 1'b1;
          if (remaining == ONE_WORD) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= ACCEPT;
            in_ready <= 1'b1;
          end
`endif
        end

`ifdef INSTR_ENC_READBACK_EN
        READ: begin
          state <= CHECK;
        end

        CHECK: begin
          if (mem_rdata != mem_data) begin
            mismatch <= 1'b1;
          end
          mem_addr      <= mem_addr + 1'b1;
          remaining     <= remaining - 1'b1;
          words_written <= words_written + 1'b1;
          if (remaining == ONE_WORD) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= ACCEPT;
            in_ready <= 1'b1;
          end
        end
`endif

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader.
// Expected words/addresses are queued as field sets are driven and matched
// against writes captured from the memory port.

module tb_instr_encoder_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   count = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        fmt = '0;
  logic [4:0]        opcode = '0;
  logic [2:0]        rd = '0, rm = '0, rn = '0;
  logic [1:0]        alu_op = '0;
  logic [10:0]       imm = '0;
  logic [3:0]        cond = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_data;
  logic              busy, done, err;
  logic [ADDR_W:0]   words_written;
`ifdef INSTR_ENC_READBACK_EN
  logic              mem_re;
  logic [15:0]       mem_rdata = 16'h0000;
  logic              mismatch;
  logic [15:0]       mem_model [256];
  int                corrupt_addr = -1;
`endif

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  opcode;
    logic [2:0]  rd, rm, rn;
    logic [1:0]  alu_op;
    logic [10:0] imm;
    logic [3:0]  cond;
    logic [15:0] word;
  } stim_t;

  stim_t       stim_q[$];
  logic [23:0] exp_q[$];
  logic [23:0] obs_q[$];
  int          total = 0;
  int          bad = 0;
  int          double_we = 0;
  logic        prev_we = 1'b0;

  instr_encoder_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .count(count), .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt),
    .opcode(opcode), .rd(rd), .rm(rm), .rn(rn), .alu_op(alu_op),
    .imm(imm), .cond(cond), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .busy(busy), .done(done), .err(err),
    .words_written(words_written)
`ifdef INSTR_ENC_READBACK_EN
    , .mem_re(mem_re), .mem_rdata(mem_rdata), .mismatch(mismatch)
`endif
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Capture every write on the memory port; flag write enables longer than a cycle
  always @(negedge clk) begin
    if (mem_we) begin
      obs_q.push_back({mem_addr, mem_data});
      if (prev_we) double_we <= double_we + 1;
    end
    prev_we <= mem_we;
  end

`ifdef INSTR_ENC_READBACK_EN
  // Synchronous instruction memory with an optional stuck bit at one address
  always @(posedge clk) begin
    if (mem_we) mem_model[mem_addr] <= (int'(mem_addr) == corrupt_addr) ? (mem_data ^ 16'h0001) : mem_data;
    if (mem_re) mem_rdata <= mem_model[mem_addr];
  end
`endif

  // Hard stop in case something hangs outside the bounded waits
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void add_stim(input logic [2:0] f, input logic [4:0] op, input logic [2:0] d,
                                   input logic [2:0] m, input logic [2:0] n, input logic [1:0] a,
                                   input logic [10:0] im, input logic [3:0] c, input logic [15:0] w);
    stim_t s;
    s.fmt = f; s.opcode = op; s.rd = d; s.rm = m; s.rn = n;
    s.alu_op = a; s.imm = im; s.cond = c; s.word = w;
    stim_q.push_back(s);
  endfunction

  // Run one load session with the queued field sets and score the writes
  task automatic run_session(input logic [7:0] base, input logic [8:0] cnt, input bit poke_start);
    logic [7:0]  addr_exp;
    logic [23:0] e, o;
    stim_t       s;
    int          n;
    bit          poke;
    addr_exp = base;
    poke = poke_start;
    obs_q.delete();
    exp_q.delete();
    double_we = 0;
    base_addr = base; count = cnt; start = 1'b1;
    tick;
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL start_busy: got %b expected 1", busy); end
    if (cnt != 0) begin
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL start_to_ready: got %b expected 1", in_ready); end
    end
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      n = 0;
      while (!in_ready && n < 20) begin tick; n++; end
      if (!in_ready) begin
        total++; bad++;
        $display("[TB] FAIL ready_timeout: in_ready got %b expected 1", in_ready);
        break;
      end
      fmt = s.fmt; opcode = s.opcode; rd = s.rd; rm = s.rm; rn = s.rn;
      alu_op = s.alu_op; imm = s.imm; cond = s.cond; in_valid = 1'b1;
      if (poke) begin start = 1'b1; base_addr = 8'h99; count = 9'd5; poke = 1'b0; end
      tick;
      in_valid = 1'b0; start = 1'b0;
      total++;
      if (mem_we !== (s.fmt < 3'd5)) begin
        bad++; $display("[TB] FAIL we_after_handshake: got %b expected %b", mem_we, (s.fmt < 3'd5));
      end
      if (s.fmt < 3'd5) begin
        exp_q.push_back({addr_exp, s.word});
        addr_exp = addr_exp + 8'd1;
`ifndef INSTR_ENC_READBACK_EN
        tick;
        total++;
        if ((in_ready | done) !== 1'b1) begin
          bad++; $display("[TB] FAIL ready_after_write: ready=%b done=%b expected one high", in_ready, done);
        end
`endif
      end else begin
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL illegal_stays_accept: got %b expected 1", in_ready); end
      end
    end
    n = 0;
    while (done !== 1'b1 && n < 30) begin tick; n++; end
    total++;
    if (done !== 1'b1) begin bad++; $display("[TB] FAIL done_timeout: done got %b expected 1", done); end
    tick;
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL done_pulse: done=%b busy=%b expected 0 0", done, busy);
    end
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++; $display("[TB] FAIL write_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      total++;
      if (o !== e) begin
        bad++; $display("[TB] FAIL write: got addr=%h data=%h expected addr=%h data=%h", o[23:16], o[15:0], e[23:16], e[15:0]);
      end
    end
    total++;
    if (double_we != 0) begin bad++; $display("[TB] FAIL we_width: got %0d long pulses expected 0", double_we); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick; tick;
    total++;
    if ({in_ready, mem_we, busy, done, err} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags: got %b expected 00000", {in_ready, mem_we, busy, done, err});
    end
    total++;
    if (mem_addr !== 8'h00 || mem_data !== 16'h0000) begin
      bad++; $display("[TB] FAIL reset_mem_port: got addr=%h data=%h expected 00 0000", mem_addr, mem_data);
    end
    total++;
    if (words_written !== 9'd0) begin bad++; $display("[TB] FAIL reset_words: got %0d expected 0", words_written); end
`ifdef INSTR_ENC_READBACK_EN
    total++;
    if ({mem_re, mismatch} !== 2'b00) begin bad++; $display("[TB] FAIL reset_readback: got %b expected 00", {mem_re, mismatch}); end
`endif
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_basic_program;
    add_stim(3'd1, 5'b00001, 3'b010, 3'b000, 3'b000, 2'b00, 11'h0F0, 4'h0, 16'h0AF0);
    add_stim(3'd0, 5'b00000, 3'b110, 3'b101, 3'b111, 2'b00, 11'h000, 4'h0, 16'h06BC);
    add_stim(3'd2, 5'b00111, 3'b001, 3'b010, 3'b000, 2'b00, 11'h018, 4'h0, 16'h3958);
    run_session(8'h10, 9'd3, 1'b0);
    total++;
    if (words_written !== 9'd3) begin bad++; $display("[TB] FAIL basic_words: got %0d expected 3", words_written); end
    total++;
    if (err !== 1'b0) begin bad++; $display("[TB] FAIL basic_err: got %b expected 0", err); end
  endtask

  task automatic test_formats;
    // Unused field bits are deliberately non-zero to show they are ignored
    add_stim(3'd3, 5'b10000, 3'b111, 3'b111, 3'b111, 2'b11, 11'h00F, 4'hF, 16'h800F);
    add_stim(3'd4, 5'b11001, 3'b101, 3'b011, 3'b110, 2'b10, 11'h70F, 4'h3, 16'hC30F);
    add_stim(3'd0, 5'b11100, 3'b000, 3'b110, 3'b000, 2'b00, 11'h7FF, 4'hA, 16'hE0C0);
    run_session(8'h40, 9'd3, 1'b0);
    total++;
    if (words_written !== 9'd3) begin bad++; $display("[TB] FAIL formats_words: got %0d expected 3", words_written); end
  endtask

  task automatic test_illegal_fmt;
    add_stim(3'd6, 5'b11111, 3'b111, 3'b111, 3'b111, 2'b11, 11'h7FF, 4'hF, 16'h0000);
    add_stim(3'd1, 5'b00010, 3'b001, 3'b000, 3'b000, 2'b00, 11'h05A, 4'h0, 16'h115A);
    add_stim(3'd2, 5'b01000, 3'b111, 3'b000, 3'b000, 2'b00, 11'h015, 4'h0, 16'h4715);
    run_session(8'h80, 9'd2, 1'b0);
    total++;
    if (err !== 1'b1) begin bad++; $display("[TB] FAIL illegal_err: got %b expected 1", err); end
    total++;
    if (words_written !== 9'd2) begin bad++; $display("[TB] FAIL illegal_words: got %0d expected 2", words_written); end
  endtask

  task automatic test_wrap;
    add_stim(3'd3, 5'b00011, 3'b000, 3'b000, 3'b000, 2'b00, 11'h7FF, 4'h0, 16'h1FFF);
    add_stim(3'd0, 5'b01010, 3'b001, 3'b010, 3'b011, 2'b11, 11'h000, 4'h0, 16'h514F);
    run_session(8'hFF, 9'd2, 1'b0);
    total++;
    if (err !== 1'b0) begin bad++; $display("[TB] FAIL wrap_err_cleared: got %b expected 0", err); end
    total++;
    if (words_written !== 9'd2) begin bad++; $display("[TB] FAIL wrap_words: got %0d expected 2", words_written); end
  endtask

  task automatic test_count_zero;
    obs_q.delete();
    base_addr = 8'h33; count = 9'd0; start = 1'b1;
    tick;
    start = 1'b0;
    total++;
    if ({done, busy, in_ready} !== 3'b110) begin
      bad++; $display("[TB] FAIL zero_done: got done/busy/ready=%b expected 110", {done, busy, in_ready});
    end
    tick;
    total++;
    if ({done, busy} !== 2'b00) begin bad++; $display("[TB] FAIL zero_idle: got done/busy=%b expected 00", {done, busy}); end
    total++;
    if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL zero_no_write: got %0d writes expected 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_write;
    obs_q.delete();
    base_addr = 8'h20; count = 9'd2; start = 1'b1;
    tick;
    start = 1'b0;
    fmt = 3'd1; opcode = 5'b00101; rd = 3'b011; imm = 11'h0C3; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    total++;
    if (mem_we !== 1'b1) begin bad++; $display("[TB] FAIL midrst_we_before: got %b expected 1", mem_we); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({mem_we, busy, in_ready, done} !== 4'b0000) begin
      bad++; $display("[TB] FAIL midrst_flags: got we/busy/ready/done=%b expected 0000", {mem_we, busy, in_ready, done});
    end
    total++;
    if (mem_addr !== 8'h00 || mem_data !== 16'h0000 || words_written !== 9'd0) begin
      bad++; $display("[TB] FAIL midrst_regs: got addr=%h data=%h words=%0d expected 00 0000 0", mem_addr, mem_data, words_written);
    end
    tick;
    total++;
    if (obs_q.size() != 0) begin bad++; $display("[TB] FAIL midrst_no_write: got %0d writes expected 0", obs_q.size()); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_start_while_busy;
    add_stim(3'd1, 5'b01100, 3'b100, 3'b000, 3'b000, 2'b00, 11'h0A5, 4'h0, 16'h64A5);
    add_stim(3'd4, 5'b10100, 3'b000, 3'b000, 3'b000, 2'b00, 11'h03C, 4'h9, 16'hA93C);
    run_session(8'h30, 9'd2, 1'b1);
    total++;
    if (words_written !== 9'd2) begin bad++; $display("[TB] FAIL busy_start_words: got %0d expected 2", words_written); end
  endtask

`ifdef INSTR_ENC_READBACK_EN
  task automatic test_readback_mismatch;
    corrupt_addr = 32'h51;
    add_stim(3'd1, 5'b00001, 3'b010, 3'b000, 3'b000, 2'b00, 11'h0F0, 4'h0, 16'h0AF0);
    add_stim(3'd3, 5'b10000, 3'b000, 3'b000, 3'b000, 2'b00, 11'h00F, 4'h0, 16'h800F);
    add_stim(3'd4, 5'b11000, 3'b000, 3'b000, 3'b000, 2'b00, 11'h00F, 4'h3, 16'hC30F);
    run_session(8'h50, 9'd3, 1'b0);
    corrupt_addr = -1;
    total++;
    if (mismatch !== 1'b1) begin bad++; $display("[TB] FAIL readback_mismatch: got %b expected 1", mismatch); end
    total++;
    if (words_written !== 9'd3) begin bad++; $display("[TB] FAIL readback_words: got %0d expected 3", words_written); end
  endtask
`endif

  // Scenario sequence
  initial begin
    $display("[TB] starting instr_encoder_loader bench");
    test_reset;
    test_basic_program;
    test_formats;
    test_illegal_fmt;
    test_wrap;
    test_count_zero;
    test_reset_mid_write;
    test_start_while_busy;
`ifdef INSTR_ENC_READBACK_EN
    test_readback_mismatch;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
